// File: rtl/dataplane_pkg.sv
// Shared dataplane types: arbiter FSM states, counter width and port-id width helper.
package dataplane_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_XFER,
    ARB_ABORT
  } arb_state_t;

  localparam int unsigned PKT_CNT_W = 32;

  function automatic int unsigned pid_width(input int unsigned n);
    if (n <= 1) begin
      return 1;
    end
    return $clog2(n);
  endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry registered AXI-Stream slice carrying data, keep, last, port id and error flag.
// in_ready depends only on the skid register, so it never combinationally follows out_ready.
module axis_skid_buffer #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned PID_W      = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   in_data,
  input  logic [DATA_WIDTH/8-1:0] in_keep,
  input  logic                    in_last,
  input  logic [PID_W-1:0]        in_pid,
  input  logic                    in_terr,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic [DATA_WIDTH/8-1:0] out_keep,
  output logic                    out_last,
  output logic [PID_W-1:0]        out_pid,
  output logic                    out_terr
);

  localparam int unsigned PW = DATA_WIDTH + DATA_WIDTH / 8 + PID_W + 2;

  logic [PW-1:0] in_pl;
  logic [PW-1:0] out_q;
  logic [PW-1:0] skid_q;
  logic          out_valid_q;
  logic          skid_valid_q;
  logic          in_fire;

  assign in_pl    = {in_data, in_keep, in_last, in_pid, in_terr};
  assign in_ready = ~skid_valid_q;
  assign in_fire  = in_valid & in_ready;

  assign out_valid = out_valid_q;
  assign {out_data, out_keep, out_last, out_pid, out_terr} = out_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q        <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else if (out_ready || !out_valid_q) begin
      // Output slot free: refill from the skid entry first to preserve order.
      if (skid_valid_q) begin
        out_q        <= skid_q;
        out_valid_q  <= 1'b1;
        skid_valid_q <= 1'b0;
      end else begin
        out_valid_q <= in_fire;
        if (in_fire) begin
          out_q <= in_pl;
        end
      end
    end else if (in_fire) begin
      skid_q       <= in_pl;
      skid_valid_q <= 1'b1;
    end
  end

endmodule

// File: rtl/ingress_port_arbiter.sv
// Packet-granular round-robin merge of NUM_PORTS AXI-Stream ports with per-port packet counters.
// Optional mid-packet stall abort and drain enabled by defining STALL_TIMEOUT_EN.
module ingress_port_arbiter
  import dataplane_pkg::*;
#(
  parameter int unsigned  NUM_PORTS      = 4,
  parameter int unsigned  DATA_WIDTH     = 64,
  parameter int unsigned  TIMEOUT_CYCLES = 1024,
  localparam int unsigned PID_W          = pid_width(NUM_PORTS),
  localparam int unsigned KEEP_W         = DATA_WIDTH / 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_PORTS-1:0]           s_tvalid,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_tdata,
  input  logic [NUM_PORTS*KEEP_W-1:0]    s_tkeep,
  input  logic [NUM_PORTS-1:0]           s_tlast,
  output logic [NUM_PORTS-1:0]           s_tready,
  input  logic [NUM_PORTS-1:0]           port_en,
  output logic                           m_tvalid,
  output logic [DATA_WIDTH-1:0]          m_tdata,
  output logic [KEEP_W-1:0]              m_tkeep,
  output logic                           m_tlast,
  output logic [PID_W-1:0]               m_port_id,
  output logic                           m_terr,
  input  logic                           m_tready,
  output logic [NUM_PORTS*PKT_CNT_W-1:0] pkt_cnt
);

  if (NUM_PORTS < 1 || NUM_PORTS > 16 || DATA_WIDTH % 8 != 0 || TIMEOUT_CYCLES < 1)
  begin : g_param_check
    $error("ingress_port_arbiter: unsupported parameter set");
  end

  arb_state_t                           state_q, state_d;
  logic [PID_W-1:0]                     grant_q, grant_d;
  logic [PID_W-1:0]                     rr_q, rr_d;
  logic [PID_W-1:0]                     next_ptr;
  logic [NUM_PORTS-1:0][PKT_CNT_W-1:0]  cnt_q;
  logic [NUM_PORTS-1:0]                 cand;
  logic                                 found;
  logic [PID_W-1:0]                     pick;

  logic                  g_valid, g_last;
  logic [DATA_WIDTH-1:0] g_data;
  logic [KEEP_W-1:0]     g_keep;
  logic                  accept;

  logic                  sk_valid, sk_ready, sk_last, sk_terr;
  logic [DATA_WIDTH-1:0] sk_data;
  logic [KEEP_W-1:0]     sk_keep;

  assign g_valid = s_tvalid[grant_q];
  assign g_last  = s_tlast[grant_q];
  assign g_data  = s_tdata[32'(grant_q) * DATA_WIDTH +: DATA_WIDTH];
  assign g_keep  = s_tkeep[32'(grant_q) * KEEP_W +: KEEP_W];
  assign accept  = (state_q == ARB_XFER) & g_valid & sk_ready;

  assign next_ptr = (grant_q == PID_W'(NUM_PORTS - 1)) ? '0 : grant_q + 1'b1;
  assign pkt_cnt  = cnt_q;

`ifdef STALL_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0]     stall_q;
  logic                 beat_seen_q;
  logic [NUM_PORTS-1:0] drain_q, drain_d;

  assign cand = s_tvalid & port_en & ~drain_q;
`else
  assign cand = s_tvalid & port_en;
`endif

  // Round-robin search starting at rr_q, wrapping modulo NUM_PORTS.
  always_comb begin
    int unsigned idx;
    found = 1'b0;
    pick  = rr_q;
    idx   = 0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      idx = (32'(rr_q) + i) % NUM_PORTS;
      if (!found && cand[idx]) begin
        found = 1'b1;
        pick  = PID_W'(idx);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_d     = rr_q;
    sk_valid = 1'b0;
    sk_data  = g_data;
    sk_keep  = g_keep;
    sk_last  = g_last;
    sk_terr  = 1'b0;
    s_tready = '0;
    case (state_q)
      ARB_IDLE: begin
        if (found) begin
          grant_d = pick;
          state_d = ARB_XFER;
        end
      end
      ARB_XFER: begin
        s_tready[grant_q] = sk_ready;
        sk_valid          = g_valid;
        if (accept && g_last) begin
          rr_d    = next_ptr;
          state_d = ARB_IDLE;
        end
`ifdef STALL_TIMEOUT_EN
        else if (beat_seen_q && !g_valid && stall_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = ARB_ABORT;
        end
`endif
      end
`ifdef STALL_TIMEOUT_EN
      ARB_ABORT: begin
        // Synthetic terminating beat closes the packet downstream.
        sk_valid = 1'b1;
        sk_data  = '0;
        sk_keep  = '0;
        sk_last  = 1'b1;
        sk_terr  = 1'b1;
        if (sk_ready) begin
          rr_d    = next_ptr;
          state_d = ARB_IDLE;
        end
      end
`endif
      default: state_d = ARB_IDLE;
    endcase
`ifdef STALL_TIMEOUT_EN
    s_tready = s_tready | drain_q;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      rr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      if (accept && g_last) begin
        cnt_q[grant_q] <= cnt_q[grant_q] + 1'b1;
      end
    end
  end

`ifdef STALL_TIMEOUT_EN
  always_comb begin
    drain_d = drain_q;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (drain_q[i] && s_tvalid[i] && s_tlast[i]) begin
        drain_d[i] = 1'b0;
      end
    end
    if (state_q == ARB_ABORT && sk_ready) begin
      drain_d[grant_q] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q     <= '0;
      beat_seen_q <= 1'b0;
      drain_q     <= '0;
    end else begin
      drain_q <= drain_d;
      if (state_q != ARB_XFER) begin
        stall_q     <= '0;
        beat_seen_q <= 1'b0;
      end else if (accept) begin
        stall_q     <= '0;
        beat_seen_q <= 1'b1;
      end else if (beat_seen_q && !g_valid) begin
        stall_q <= stall_q + 1'b1;
      end
    end
  end
`endif

  axis_skid_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .PID_W      (PID_W)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (sk_valid),
    .in_ready  (sk_ready),
    .in_data   (sk_data),
    .in_keep   (sk_keep),
    .in_last   (sk_last),
    .in_pid    (grant_q),
    .in_terr   (sk_terr),
    .out_valid (m_tvalid),
    .out_ready (m_tready),
    .out_data  (m_tdata),
    .out_keep  (m_tkeep),
    .out_last  (m_tlast),
    .out_pid   (m_port_id),
    .out_terr  (m_terr)
  );

endmodule

// File: tb/tb_ingress_port_arbiter.sv
// Directed bench for ingress_port_arbiter; the stall-abort scenario is built with STALL_TIMEOUT_EN.
module tb_ingress_port_arbiter;

  localparam int NP = 4;
  localparam int DW = 64;
  localparam int KW = DW / 8;
`ifdef STALL_TIMEOUT_EN
  localparam int TMO = 16;
`else
  localparam int TMO = 1024;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [NP-1:0]     s_tvalid;
  logic [NP*DW-1:0]  s_tdata;
  logic [NP*KW-1:0]  s_tkeep;
  logic [NP-1:0]     s_tlast;
  logic [NP-1:0]     s_tready;
  logic [NP-1:0]     port_en;
  logic              m_tvalid;
  logic [DW-1:0]     m_tdata;
  logic [KW-1:0]     m_tkeep;
  logic              m_tlast;
  logic [1:0]        m_port_id;
  logic              m_terr;
  logic              m_tready;
  logic [NP*32-1:0]  pkt_cnt;

  ingress_port_arbiter #(
    .NUM_PORTS      (NP),
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .s_tvalid  (s_tvalid),
    .s_tdata   (s_tdata),
    .s_tkeep   (s_tkeep),
    .s_tlast   (s_tlast),
    .s_tready  (s_tready),
    .port_en   (port_en),
    .m_tvalid  (m_tvalid),
    .m_tdata   (m_tdata),
    .m_tkeep   (m_tkeep),
    .m_tlast   (m_tlast),
    .m_port_id (m_port_id),
    .m_terr    (m_terr),
    .m_tready  (m_tready),
    .pkt_cnt   (pkt_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
  } beat_t;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    logic [1:0]  pid;
    logic        terr;
    logic [31:0] cyc;
  } obs_t;

  beat_t src_q[NP][$];
  obs_t  mon_q[$];
  int    cyc = 0;
  int    start_cyc[NP];
  int    vectors = 0;
  int    errors = 0;

  function automatic logic [63:0] mk(input int p, input int k, input int b);
    return 64'hD00D_0000_0000_0000 | (64'(p) << 32) | (64'(k) << 16) | 64'(b);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst && m_tvalid && m_tready) begin
      mon_q.push_back({m_tdata, m_tkeep, m_tlast, m_port_id, m_terr, 32'(cyc)});
    end
  end

  // Source model: presents the head of each port queue, pops on a sampled handshake.
  initial begin : driver
    logic [NP-1:0] fire;
    s_tvalid = '0;
    s_tdata  = '0;
    s_tkeep  = '0;
    s_tlast  = '0;
    forever begin
      @(negedge clk);
      fire = s_tvalid & s_tready;
      @(posedge clk);
      #1;
      for (int i = 0; i < NP; i++) begin
        if (fire[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        if (src_q[i].size() > 0) begin
          if (!s_tvalid[i]) start_cyc[i] = cyc;
          s_tvalid[i]           = 1'b1;
          s_tdata[i*DW +: DW]   = src_q[i][0].data;
          s_tkeep[i*KW +: KW]   = src_q[i][0].keep;
          s_tlast[i]            = src_q[i][0].last;
        end else begin
          s_tvalid[i]           = 1'b0;
          s_tdata[i*DW +: DW]   = '0;
          s_tkeep[i*KW +: KW]   = '0;
          s_tlast[i]            = 1'b0;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion, required finish before 2ms");
    $fatal(1);
  end

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < NP; i++) src_q[i].delete();
    s_tvalid = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    mon_q.delete();
    @(negedge clk);
  endtask

  task automatic wait_beats(input int n, input int budget, input string name);
    for (int k = 0; k < budget && mon_q.size() < n; k++) begin
      @(negedge clk);
      #1;
    end
    vectors++;
    if (mon_q.size() < n) begin
      errors++;
      $display("FAIL %s_timeout: got %0d beats, required %0d", name, mon_q.size(), n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if ({s_tready, m_tvalid, m_tlast, m_terr, m_port_id} !== '0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b, required 0",
               {s_tready, m_tvalid, m_tlast, m_terr, m_port_id});
    end
    vectors++;
    if ({m_tdata, m_tkeep} !== '0) begin
      errors++;
      $display("FAIL reset_data: got %h, required 0", {m_tdata, m_tkeep});
    end
    vectors++;
    if (pkt_cnt !== '0) begin
      errors++;
      $display("FAIL reset_cnt: got %h, required 0", pkt_cnt);
    end
    do_reset();
  endtask

  task automatic test_single_port();
    logic [7:0] keeps [3];
    obs_t exp;
    keeps = '{8'hFF, 8'hFF, 8'h0F};
    do_reset();
    for (int b = 0; b < 3; b++) src_q[2].push_back({mk(2, 0, b), keeps[b], b == 2});
    wait_beats(3, 40, "single");
    for (int b = 0; b < 3 && b < mon_q.size(); b++) begin
      exp = {mk(2, 0, b), keeps[b], b == 2, 2'd2, 1'b0, 32'd0};
      vectors++;
      if (mon_q[b][72:33] !== exp[72:33] || mon_q[b][104:73] !== exp[104:73]) begin
        errors++;
        $display("FAIL single_beat%0d: got %h, required %h", b, mon_q[b][104:32], exp[104:32]);
      end
      vectors++;
      if (mon_q[b].cyc !== 32'(start_cyc[2] + 2 + b)) begin
        errors++;
        $display("FAIL single_lat%0d: got cycle %0d, required %0d", b, mon_q[b].cyc,
                 start_cyc[2] + 2 + b);
      end
    end
    vectors++;
    if (pkt_cnt !== {32'd0, 32'd1, 32'd0, 32'd0}) begin
      errors++;
      $display("FAIL single_cnt: got %h, required port2=1", pkt_cnt);
    end
  endtask

  task automatic test_fairness();
    int order[3];
    int p, k;
    order = '{0, 1, 3};
    do_reset();
    for (int pk = 0; pk < 2; pk++) begin
      foreach (order[j]) begin
        src_q[order[j]].push_back({mk(order[j], pk, 0), 8'hFF, 1'b0});
        src_q[order[j]].push_back({mk(order[j], pk, 1), 8'hFF, 1'b1});
      end
    end
    wait_beats(12, 200, "fair");
    for (int n = 0; n < 12 && n < mon_q.size(); n++) begin
      p = order[(n / 2) % 3];
      k = n / 6;
      vectors++;
      if (mon_q[n].data !== mk(p, k, n % 2) || mon_q[n].pid !== 2'(p) ||
          mon_q[n].last !== ((n % 2) == 1)) begin
        errors++;
        $display("FAIL fair_beat%0d: got data %h pid %0d last %0d, required data %h pid %0d",
                 n, mon_q[n].data, mon_q[n].pid, mon_q[n].last, mk(p, k, n % 2), p);
      end
      if (n > 0) begin
        vectors++;
        if (mon_q[n].cyc - mon_q[n-1].cyc !== ((n % 2) == 1 ? 32'd1 : 32'd2)) begin
          errors++;
          $display("FAIL fair_gap%0d: got %0d cycles, required %0d", n,
                   mon_q[n].cyc - mon_q[n-1].cyc, (n % 2) == 1 ? 1 : 2);
        end
      end
    end
    vectors++;
    if (pkt_cnt !== {32'd2, 32'd0, 32'd2, 32'd2}) begin
      errors++;
      $display("FAIL fair_cnt: got %h, required 2,0,2,2", pkt_cnt);
    end
  endtask

  task automatic test_backpressure();
    logic              prev_stall, prev_fill;
    logic [DW+KW+3:0]  snap;
    int                fills;
    prev_stall = 1'b0;
    prev_fill  = 1'b0;
    snap       = '0;
    fills      = 0;
    do_reset();
    for (int b = 0; b < 8; b++) src_q[0].push_back({mk(0, 0, b), b == 7 ? 8'h01 : 8'hFF, b == 7});
    for (int k = 0; k < 50; k++) begin
      @(posedge clk);
      #1;
      m_tready = k[0];
      @(negedge clk);
      if (prev_stall) begin
        vectors++;
        if ({m_tvalid, m_tdata, m_tkeep, m_tlast, m_port_id} !== snap) begin
          errors++;
          $display("FAIL bp_hold: got %h, required %h",
                   {m_tvalid, m_tdata, m_tkeep, m_tlast, m_port_id}, snap);
        end
      end
      if (prev_fill) begin
        fills++;
        vectors++;
        if (s_tready[0] !== 1'b0) begin
          errors++;
          $display("FAIL bp_ready: got s_tready %b, required 0 with skid full", s_tready[0]);
        end
      end
      prev_stall = m_tvalid & ~m_tready;
      prev_fill  = m_tvalid & ~m_tready & s_tvalid[0] & s_tready[0];
      snap       = {m_tvalid, m_tdata, m_tkeep, m_tlast, m_port_id};
    end
    m_tready = 1'b1;
    wait_beats(8, 20, "bp");
    vectors++;
    if (fills == 0) begin
      errors++;
      $display("FAIL bp_fill: got %0d skid fills, required at least 1", fills);
    end
    for (int b = 0; b < 8 && b < mon_q.size(); b++) begin
      vectors++;
      if (mon_q[b].data !== mk(0, 0, b) || mon_q[b].last !== (b == 7) ||
          mon_q[b].keep !== (b == 7 ? 8'h01 : 8'hFF)) begin
        errors++;
        $display("FAIL bp_beat%0d: got %h, required %h", b, mon_q[b].data, mk(0, 0, b));
      end
    end
  endtask

  task automatic test_enable_mask();
    do_reset();
    port_en = 4'b1010;
    foreach (src_q[i]) begin
      for (int pk = 0; pk < (i == 1 ? 2 : 1); pk++) begin
        for (int b = 0; b < (i == 1 ? 4 : 2); b++) begin
          src_q[i].push_back({mk(i, pk, b), 8'hFF, b == (i == 1 ? 3 : 1)});
        end
      end
    end
    wait_beats(1, 20, "en_first");
    port_en[1] = 1'b0;
    wait_beats(6, 60, "en");
    repeat (20) @(negedge clk);
    #1;
    vectors++;
    if (mon_q.size() !== 6) begin
      errors++;
      $display("FAIL en_count: got %0d beats, required 6", mon_q.size());
    end
    for (int n = 0; n < 6 && n < mon_q.size(); n++) begin
      vectors++;
      if (mon_q[n].pid !== (n < 4 ? 2'd1 : 2'd3) ||
          mon_q[n].data !== (n < 4 ? mk(1, 0, n) : mk(3, 0, n - 4))) begin
        errors++;
        $display("FAIL en_beat%0d: got pid %0d data %h, required pid %0d", n, mon_q[n].pid,
                 mon_q[n].data, n < 4 ? 1 : 3);
      end
    end
    vectors++;
    if (pkt_cnt !== {32'd1, 32'd0, 32'd1, 32'd0}) begin
      errors++;
      $display("FAIL en_cnt: got %h, required 1,0,1,0", pkt_cnt);
    end
    port_en = '1;
  endtask

  task automatic test_reset_midpacket();
    do_reset();
    src_q[2].push_back({mk(2, 0, 0), 8'hFF, 1'b1});
    wait_beats(1, 20, "rst_pre");
    for (int b = 0; b < 4; b++) src_q[1].push_back({mk(1, 0, b), 8'hFF, b == 3});
    wait_beats(3, 30, "rst_mid");
    rst = 1'b1;
    for (int i = 0; i < NP; i++) src_q[i].delete();
    s_tvalid = '0;
    @(negedge clk);
    vectors++;
    if ({s_tready, m_tvalid, m_tlast, m_terr, m_port_id, m_tdata, m_tkeep} !== '0) begin
      errors++;
      $display("FAIL rst_outputs: got %h, required 0",
               {s_tready, m_tvalid, m_tlast, m_terr, m_port_id, m_tdata, m_tkeep});
    end
    vectors++;
    if (pkt_cnt !== '0) begin
      errors++;
      $display("FAIL rst_cnt: got %h, required 0", pkt_cnt);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    mon_q.delete();
    src_q[3].push_back({mk(3, 1, 0), 8'hFF, 1'b1});
    src_q[0].push_back({mk(0, 1, 0), 8'hFF, 1'b1});
    wait_beats(2, 30, "rst_post");
    if (mon_q.size() >= 2) begin
      vectors++;
      if (mon_q[0].pid !== 2'd0 || mon_q[0].data !== mk(0, 1, 0) || mon_q[1].pid !== 2'd3) begin
        errors++;
        $display("FAIL rst_first: got pid %0d then %0d, required 0 then 3",
                 mon_q[0].pid, mon_q[1].pid);
      end
    end
  endtask

`ifdef STALL_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    src_q[1].push_back({mk(1, 0, 0), 8'hFF, 1'b0});
    wait_beats(1, 20, "tmo_first");
    repeat (30) @(negedge clk);
    src_q[1].push_back({mk(1, 0, 1), 8'hFF, 1'b0});
    src_q[1].push_back({mk(1, 0, 2), 8'hFF, 1'b1});
    repeat (20) @(negedge clk);
    #1;
    vectors++;
    if (mon_q.size() !== 2) begin
      errors++;
      $display("FAIL tmo_count: got %0d beats, required 2", mon_q.size());
    end
    if (mon_q.size() >= 2) begin
      vectors++;
      if (mon_q[1].data !== '0 || mon_q[1].keep !== '0 || mon_q[1].last !== 1'b1 ||
          mon_q[1].pid !== 2'd1 || mon_q[1].terr !== 1'b1) begin
        errors++;
        $display("FAIL tmo_abort: got %h, required data 0 keep 0 last 1 pid 1 terr 1",
                 mon_q[1][104:32]);
      end
    end
    vectors++;
    if (pkt_cnt[63:32] !== 32'd0) begin
      errors++;
      $display("FAIL tmo_cnt: got %0d, required 0", pkt_cnt[63:32]);
    end
    src_q[1].push_back({mk(1, 1, 0), 8'hFF, 1'b1});
    wait_beats(3, 30, "tmo_next");
    if (mon_q.size() >= 3) begin
      vectors++;
      if (mon_q[2].data !== mk(1, 1, 0) || mon_q[2].terr !== 1'b0) begin
        errors++;
        $display("FAIL tmo_next: got %h, required %h", mon_q[2].data, mk(1, 1, 0));
      end
    end
  endtask
`endif

  initial begin
    rst      = 1'b1;
    port_en  = '1;
    m_tready = 1'b1;
    test_reset();
    test_single_port();
    test_fairness();
    test_backpressure();
    test_enable_mask();
    test_reset_midpacket();
`ifdef STALL_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
